// File: rtl/pipeline_stage_array_if.sv
// Handshake, flush and stall bundle for pipeline_stage_array.
// The master side is the surrounding logic; the slave side is the pipeline.
interface pipeline_stage_array_if #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 3
);
    logic              in_valid_i;
    logic [WIDTH-1:0]  in_data_i;
    logic              in_ready_o;
    logic              out_valid_o;
    logic [WIDTH-1:0]  out_data_o;
    logic              out_ready_i;
    logic [STAGES-1:0] flush_i;
    logic              stall_all_i;
    logic [CNT_W-1:0]  occupancy_o;

    modport master (
        output in_valid_i, in_data_i, out_ready_i, flush_i, stall_all_i,
        input  in_ready_o, out_valid_o, out_data_o, occupancy_o
    );

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i, flush_i, stall_all_i,
        output in_ready_o, out_valid_o, out_data_o, occupancy_o
    );
endinterface

// File: rtl/pipeline_stage_array.sv
// Valid/ready register pipeline with per-stage flush and a global stall.
// Define PIPE_BUBBLE_COLLAPSE_EN to let empty stages fill while the output is blocked.
module pipeline_stage_array #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int CNT_W  = 3
) (
    input logic                   clk_i,
    input logic                   rst_i,
    pipeline_stage_array_if.slave bus
);
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];
    logic [STAGES-1:0] ev;
    logic [STAGES-1:0] en;
    logic              chain;
    logic [CNT_W-1:0]  occ;

    assign ev = valid_q & ~bus.flush_i;

    // A scalar carries the enable down the chain so the vector never feeds itself.
    always_comb begin
        en    = '0;
        chain = ~ev[STAGES-1] | bus.out_ready_i;
        en[STAGES-1] = chain;
`ifdef PIPE_BUBBLE_COLLAPSE_EN
        for (int i = STAGES - 2; i >= 0; i--) begin
            chain = ~ev[i] | chain;
            en[i] = chain;
        end
`else
        for (int i = 0; i < STAGES - 1; i++) begin
            en[i] = chain;
        end
`endif
    end

    always_comb begin
        valid_d = valid_q;
        for (int i = 0; i < STAGES; i++) begin
            data_d[i] = data_q[i];
        end
        if (!bus.stall_all_i) begin
            valid_d = ev;
            if (en[0]) begin
                valid_d[0] = bus.in_valid_i;
                if (bus.in_valid_i) begin
                    data_d[0] = bus.in_data_i;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (en[i]) begin
                    valid_d[i] = ev[i-1];
                    if (ev[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    // Occupancy counts raw registered valids, so a pending flush is still counted.
    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + CNT_W'(valid_q[i]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.in_ready_o  = en[0] & ~bus.stall_all_i;
    assign bus.out_valid_o = ev[STAGES-1] & ~bus.stall_all_i;
    assign bus.out_data_o  = data_q[STAGES-1];
    assign bus.occupancy_o = occ;
endmodule

// File: doc/pipeline_stage_array.md
PIPELINE_STAGE_ARRAY -- requirements
Module: pipeline_stage_array

Interface
REQ-001 Parameter WIDTH, default 32, payload bits per stage (legal 1..128).
REQ-002 Parameter STAGES, default 4, number of register stages (legal 1..16); stage 0 is entry, stage STAGES-1 is output.
REQ-003 Parameter CNT_W, default 3, occupancy width; SHALL equal clog2(STAGES+1).
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock, all state updates on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 in_valid_i  input  1  upstream offers in_data_i.
REQ-008 in_data_i  input  WIDTH  payload entering stage 0.
REQ-009 in_ready_o  output  1  stage 0 can load this cycle.
REQ-010 out_valid_o  output  1  stage STAGES-1 holds live payload.
REQ-011 out_data_o  output  WIDTH  payload of stage STAGES-1.
REQ-012 out_ready_i  input  1  downstream accepts out_data_o.
REQ-013 flush_i  input  STAGES  per-stage kill mask, bit i kills the stage i content.
REQ-014 stall_all_i  input  1  global freeze.
REQ-015 occupancy_o  output  CNT_W  count of set stage valid bits.

Function
REQ-016 Each stage holds valid[i] and data[i]; effective valid ev[i] = valid[i] & ~flush_i[i].
REQ-017 Handshake: a transfer occurs when valid and ready are both high on a rising edge; in_ready_o SHALL not depend on in_valid_i.
REQ-018 out_valid_o = ev[STAGES-1] & ~stall_all_i; out_data_o = data[STAGES-1], combinational from registers only plus flush/stall gating.
REQ-019 Advance enable: en[STAGES-1] = ~ev[STAGES-1] | out_ready_i; en[i] per Configuration.
REQ-020 When en[i], stage i loads valid[i] <= ev[i-1] (i>0) or in_valid_i (i=0), and data[i] loads only if that incoming valid is 1; otherwise data[i] holds.
REQ-021 When ~en[i], valid[i] <= ev[i] (flushed content dropped, live content held).
REQ-022 in_ready_o = en[0] & ~stall_all_i.
REQ-023 Latency: with no stalls, a payload accepted at edge N appears on out_valid_o after edge N+STAGES-1 (STAGES cycles, register-to-output).
REQ-024 Full throughput: one payload per cycle sustained when out_ready_i=1 and in_valid_i=1.
REQ-025 stall_all_i=1: no register changes, flush_i ignored, in_ready_o=0, out_valid_o=0.
REQ-026 Flush and load same cycle at stage 0: old content killed, new input accepted if in_ready_o.
REQ-027 Flush of output stage in the same cycle as out_ready_i=1: no transfer occurs (out_valid_o=0).
REQ-028 occupancy_o = popcount(valid[]), registered state, not ev.
REQ-029 STAGES=1: single register; in_ready_o = ~ev[0] | out_ready_i.

Reset
REQ-030 rst_i high SHALL immediately clear all valid[i] and data[i] to 0, irrespective of clk_i.
REQ-031 During and right after reset: out_valid_o=0, out_data_o=0, occupancy_o=0, in_ready_o=~stall_all_i.
REQ-032 Reset mid-stream discards all in-flight payloads; no partial transfer after deassertion.

Configuration
REQ-033 Macro PIPE_BUBBLE_COLLAPSE_EN defined: en[i] = ~ev[i] | en[i+1] for i<STAGES-1; empty stages fill while downstream is stalled.
REQ-034 Macro undefined: lockstep, en[i] = en[STAGES-1] for all i; bubbles preserved, whole chain frozen when output stalled.

Verification
REQ-035 Reset, then STAGES=4, stream 0x1..0x8 with out_ready_i=1 -> out 0x1 valid after 4th edge, then 0x2..0x8 on consecutive cycles, occupancy_o=4 steady.
REQ-036 Fill 4 stages, hold out_ready_i=0 -> in_ready_o=0, occupancy_o=4, out_data_o stable 0x1; release -> 0x1..0x4 drained in order.
REQ-037 Single payload 0xA then idle, out_ready_i=0 for 5 cycles, with collapse macro -> 0xA at output, occupancy_o=1, in_ready_o=1; without macro -> in_ready_o=0 while 0xA waits.
REQ-038 Stages hold 0x1..0x4, pulse flush_i=4'b0110 one cycle -> output sequence 0x1,0x4 only, occupancy drops by 2.
REQ-039 stall_all_i=1 for 3 cycles mid-stream with in_valid_i=1, flush_i=4'hF -> no state change, out_valid_o=0, no payload lost or duplicated after release.
REQ-040 Assert rst_i asynchronously between edges with 3 payloads in flight -> out_valid_o and occupancy_o go 0 before next edge; post-reset output shows only new payloads.
